snoopy_invalidate_controller: RTL and testbench

// - Snoop-side controller for the MSI invalidate-protocol cache unit. Drives the cache's controller-side port
//   (index/offset/tagIn/stateIn/writeState) and consumes its outputs (dataOut/cacheNumber/stateOut/hit).
// - Accepts one bus snoop at a time and looks up the line. Flushes a MODIFIED line word-by-word,

---
 rtl/msi_protocol_pkg.sv | 30 +++
 rtl/snoop_flush_sequencer.sv | 37 +++
 rtl/snoopy_invalidate_controller.sv | 190 +++++++++++++++++++
 tb/tb_snoopy_invalidate_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_protocol_pkg.sv
// Shared MSI protocol definitions: line states, bus snoop commands and the snoop controller FSM states.
package msi_protocol_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } msi_state_e;

  typedef enum logic [1:0] {
    BUS_RESERVED       = 2'b00,
    BUS_READ           = 2'b01,
    BUS_READ_EXCLUSIVE = 2'b10,
    BUS_INVALIDATE     = 2'b11
  } bus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FLUSH,
    ST_UPDATE,
    ST_RESPOND
  } snoop_fsm_e;

  // Only commands that hand the line to another cache need dirty data written back.
  function automatic logic needs_writeback(input bus_cmd_e cmd);
    return (cmd == BUS_READ) || (cmd == BUS_READ_EXCLUSIVE);
  endfunction

endpackage

// File: rtl/snoop_flush_sequencer.sv
// Walks the word offsets of a line during a flush; advances one word per accepted beat and
// flags the beat that completes the line. Holds its offset (and so the word) while the bus stalls.
module snoop_flush_sequencer #(
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    active_i,
  input  logic                    flush_ready_i,
  output logic [OFFSET_WIDTH-1:0] offset_o,
  output logic                    flush_valid_o,
  output logic                    last_beat_o
);

  logic [OFFSET_WIDTH-1:0] count_q, count_d;

  // The counter wraps to zero on the last beat, so every flush starts at word 0.
  always_comb begin
    count_d = count_q;
    if (active_i && flush_ready_i) begin
      count_d = count_q + OFFSET_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign offset_o      = count_q;
  assign flush_valid_o = active_i;
  assign last_beat_o   = active_i && flush_ready_i && (&count_q);

endmodule

// File: rtl/snoopy_invalidate_controller.sv
// Snoop-side MSI controller: lookup, optional word-by-word flush, state rewrite, then a held response.
// Optional hit/invalidate counters are built when SNOOPY_CONTROLLER_STATISTICS_EN is defined.
module snoopy_invalidate_controller
  import msi_protocol_pkg::*;
#(
  parameter int  TAG_WIDTH         = 6,
  parameter int  INDEX_WIDTH       = 6,
  parameter int  OFFSET_WIDTH      = 4,
  parameter int  SET_ASSOCIATIVITY = 2,
  parameter int  DATA_WIDTH        = 16,
  localparam int ADDRESS_WIDTH     = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         snoopValid,
  output logic                         snoopReady,
  input  logic [ADDRESS_WIDTH-1:0]     snoopAddress,
  input  logic [1:0]                   snoopCommand,
  output logic                         flushValid,
  output logic [DATA_WIDTH-1:0]        flushData,
  input  logic                         flushReady,
  output logic                         responseValid,
  output logic                         responseHit,
  output logic                         responseFlush,
  input  logic                         responseReady,
  output logic [INDEX_WIDTH-1:0]       index,
  output logic [OFFSET_WIDTH-1:0]      offset,
  output logic [TAG_WIDTH-1:0]         tagIn,
  output logic [1:0]                   stateIn,
  output logic                         writeState,
  input  logic [DATA_WIDTH-1:0]        dataOut,
  input  logic [SET_ASSOCIATIVITY-1:0] cacheNumber,
  input  logic [1:0]                   stateOut,
  input  logic                         hit
`ifdef SNOOPY_CONTROLLER_STATISTICS_EN
  ,
  output logic [15:0]                  snoopHitCount,
  output logic [15:0]                  invalidateCount
`endif
);

  snoop_fsm_e             state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  bus_cmd_e               cmd_q, cmd_d;
  logic                   resp_hit_q, resp_hit_d;
  logic                   resp_flush_q, resp_flush_d;

  logic                    flush_active;
  logic                    flush_valid;
  logic                    last_beat;
  logic [OFFSET_WIDTH-1:0] flush_offset;
  logic                    line_present;

  // The way number and the snooped word offset play no part in a whole-line snoop.
  logic unused_inputs;
  assign unused_inputs = ^{cacheNumber, snoopAddress[OFFSET_WIDTH-1:0]};

  assign line_present = hit && (stateOut != INVALID);

  snoop_flush_sequencer #(
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_flush_seq (
    .clock         (clock),
    .reset         (reset),
    .active_i      (flush_active),
    .flush_ready_i (flushReady),
    .offset_o      (flush_offset),
    .flush_valid_o (flush_valid),
    .last_beat_o   (last_beat)
  );

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    idx_d         = idx_q;
    cmd_d         = cmd_q;
    resp_hit_d    = resp_hit_q;
    resp_flush_d  = resp_flush_q;
    snoopReady    = 1'b0;
    responseValid = 1'b0;
    writeState    = 1'b0;
    stateIn       = INVALID;
    index         = '0;
    tagIn         = '0;
    flush_active  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        snoopReady = 1'b1;
        if (snoopValid) begin
          tag_d   = snoopAddress[ADDRESS_WIDTH-1 -: TAG_WIDTH];
          idx_d   = snoopAddress[OFFSET_WIDTH +: INDEX_WIDTH];
          cmd_d   = bus_cmd_e'(snoopCommand);
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        index        = idx_q;
        tagIn        = tag_q;
        resp_hit_d   = line_present;
        resp_flush_d = 1'b0;
        if (!line_present || (cmd_q == BUS_RESERVED)) begin
          state_d = ST_RESPOND;
        end else if ((stateOut == MODIFIED) && needs_writeback(cmd_q)) begin
          resp_flush_d = 1'b1;
          state_d      = ST_FLUSH;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_FLUSH: begin
        index        = idx_q;
        tagIn        = tag_q;
        flush_active = 1'b1;
        if (last_beat) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        index      = idx_q;
        tagIn      = tag_q;
        writeState = 1'b1;
        stateIn    = (cmd_q == BUS_READ) ? SHARED : INVALID;
        state_d    = ST_RESPOND;
      end
      ST_RESPOND: begin
        responseValid = 1'b1;
        if (responseReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      cmd_q        <= BUS_RESERVED;
      resp_hit_q   <= 1'b0;
      resp_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      cmd_q        <= cmd_d;
      resp_hit_q   <= resp_hit_d;
      resp_flush_q <= resp_flush_d;
    end
  end

  assign flushValid    = flush_valid;
  assign offset        = flush_valid ? flush_offset : '0;
  assign flushData     = flush_valid ? dataOut : '0;
  assign responseHit   = responseValid && resp_hit_q;
  assign responseFlush = responseValid && resp_flush_q;

`ifdef SNOOPY_CONTROLLER_STATISTICS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] inv_cnt_q, inv_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    inv_cnt_d = inv_cnt_q;
    if ((state_q == ST_LOOKUP) && line_present && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (writeState && (stateIn == INVALID) && (inv_cnt_q != 16'hFFFF)) begin
      inv_cnt_d = inv_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q <= '0;
      inv_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign snoopHitCount   = hit_cnt_q;
  assign invalidateCount = inv_cnt_q;
`endif

endmodule

// File: tb/tb_snoopy_invalidate_controller.sv
// Bench for snoopy_invalidate_controller: a cache memory model, a transaction-level reference of the
// snoop outcome checked every cycle, directed scenarios with literal expectations, then random snoops.
module tb_snoopy_invalidate_controller;
  import msi_protocol_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        snoopValid = 1'b0;
  logic        snoopReady;
  logic [15:0] snoopAddress = '0;
  logic [1:0]  snoopCommand = '0;
  logic        flushValid;
  logic [15:0] flushData;
  logic        flushReady = 1'b0;
  logic        responseValid, responseHit, responseFlush;
  logic        responseReady = 1'b0;
  logic [5:0]  index, tagIn;
  logic [3:0]  offset;
  logic [1:0]  stateIn;
  logic        writeState;
  logic [15:0] dataOut;
  logic [1:0]  cacheNumber;
  logic [1:0]  stateOut;
  logic        hit;
`ifdef SNOOPY_CONTROLLER_STATISTICS_EN
  logic [15:0] snoopHitCount, invalidateCount;
`endif

  int checks = 0;
  int errors = 0;
  int fmode  = 0;

  always #5 clock = ~clock;

  snoopy_invalidate_controller dut (
    .clock(clock), .reset(reset),
    .snoopValid(snoopValid), .snoopReady(snoopReady),
    .snoopAddress(snoopAddress), .snoopCommand(snoopCommand),
    .flushValid(flushValid), .flushData(flushData), .flushReady(flushReady),
    .responseValid(responseValid), .responseHit(responseHit),
    .responseFlush(responseFlush), .responseReady(responseReady),
    .index(index), .offset(offset), .tagIn(tagIn), .stateIn(stateIn),
    .writeState(writeState), .dataOut(dataOut), .cacheNumber(cacheNumber),
    .stateOut(stateOut), .hit(hit)
`ifdef SNOOPY_CONTROLLER_STATISTICS_EN
    , .snoopHitCount(snoopHitCount), .invalidateCount(invalidateCount)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cache memory seen by the DUT ----------------
  bit       present_a [64][64];
  bit [1:0] state_a   [64][64];

  function automatic logic [15:0] word_of(input logic [5:0] t, input logic [5:0] ix,
                                          input logic [3:0] o);
    return {t, ix, o} ^ 16'hC3A5;
  endfunction

  always_comb begin
    hit         = present_a[tagIn][index];
    stateOut    = state_a[tagIn][index];
    dataOut     = word_of(tagIn, index, offset);
    cacheNumber = tagIn[1:0];
  end

  // ---------------- reference model of the snoop outcome ----------------
  typedef enum {P_IDLE, P_LOOKUP, P_FLUSH, P_UPDATE, P_RESPOND} phase_t;

  bit         m_busy, m_lookup, m_flush, m_write, m_written, m_rhit;
  int         m_beats;
  logic [1:0] m_cmd, m_wval;
  logic [5:0] m_tag, m_idx;
  int         m_hitcnt, m_invcnt;
  phase_t     ph_m, ph_c;

  bit       pre_vld;
  bit       pre_p;
  bit [1:0] pre_s;
  logic [5:0] pre_t, pre_i;

  function automatic phase_t phase();
    if (!m_busy) return P_IDLE;
    if (m_lookup) return P_LOOKUP;
    if (m_flush && m_beats < 16) return P_FLUSH;
    if (m_write && !m_written) return P_UPDATE;
    return P_RESPOND;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_lookup = 1'b0;
      m_hitcnt = 0;
      m_invcnt = 0;
    end else begin
      ph_m = phase();
      if (pre_vld) begin
        present_a[pre_t][pre_i] <= pre_p;
        state_a[pre_t][pre_i]   <= pre_s;
      end
      if (writeState) state_a[tagIn][index] <= stateIn;
      case (ph_m)
        P_IDLE: if (snoopValid) begin
          m_tag     = snoopAddress[15:10];
          m_idx     = snoopAddress[9:4];
          m_cmd     = snoopCommand;
          m_rhit    = present_a[m_tag][m_idx] && (state_a[m_tag][m_idx] != INVALID);
          m_flush   = m_rhit && (state_a[m_tag][m_idx] == MODIFIED) && (m_cmd == 2'b01 || m_cmd == 2'b10);
          m_write   = m_rhit && (m_cmd != 2'b00);
          m_wval    = (m_cmd == 2'b01) ? SHARED : INVALID;
          m_beats   = 0;
          m_written = 1'b0;
          m_lookup  = 1'b1;
          m_busy    = 1'b1;
        end
        P_LOOKUP: begin
          m_lookup = 1'b0;
          if (m_rhit && m_hitcnt < 65535) m_hitcnt++;
        end
        P_FLUSH:  if (flushReady) m_beats++;
        P_UPDATE: begin
          m_written = 1'b1;
          if (m_wval == INVALID && m_invcnt < 65535) m_invcnt++;
        end
        P_RESPOND: if (responseReady) m_busy = 1'b0;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the reference.
  always @(negedge clock) begin
    ph_c = phase();
    chk("snoopReady", snoopReady, ph_c == P_IDLE);
    chk("flushValid", flushValid, ph_c == P_FLUSH);
    chk("writeState", writeState, ph_c == P_UPDATE);
    chk("responseValid", responseValid, ph_c == P_RESPOND);
    if (ph_c == P_RESPOND) begin
      chk("responseHit", responseHit, m_rhit);
      chk("responseFlush", responseFlush, m_flush);
    end
    if (ph_c == P_LOOKUP || ph_c == P_FLUSH || ph_c == P_UPDATE) begin
      chk("index", index, m_idx);
      chk("tagIn", tagIn, m_tag);
    end
    if (ph_c == P_FLUSH) begin
      chk("flush_offset", offset, m_beats[3:0]);
      chk("flushData", flushData, word_of(m_tag, m_idx, m_beats[3:0]));
    end
    if (ph_c == P_UPDATE) chk("stateIn", stateIn, m_wval);
    if (reset) chk("reset_outputs_zero", {index, offset, tagIn, stateIn, flushData, responseHit, responseFlush}, 0);
`ifdef SNOOPY_CONTROLLER_STATISTICS_EN
    chk("snoopHitCount", snoopHitCount, m_hitcnt);
    chk("invalidateCount", invalidateCount, m_invcnt);
`endif
  end

  // flushReady pattern: 0 = always ready, 1 = toggling, 2 = random.
  initial forever begin
    @(posedge clock);
    #1;
    case (fmode)
      0: flushReady = 1'b1;
      1: flushReady = !flushReady;
      default: flushReady = 1'($urandom);
    endcase
  end

  task automatic preload(input logic [5:0] t, input logic [5:0] ix, input bit p, input bit [1:0] s);
    pre_t = t; pre_i = ix; pre_p = p; pre_s = s; pre_vld = 1'b1;
    @(posedge clock); #1;
    pre_vld = 1'b0;
  endtask

  // Issue one snoop; lat counts cycles from the accept cycle to the first responseValid.
  task automatic snoop(input logic [5:0] t, input logic [5:0] ix, input logic [3:0] off,
                       input logic [1:0] cmd, input int rdelay,
                       output int lat, output logic rh, output logic rf);
    int n;
    n = 0;
    snoopAddress = {t, ix, off};
    snoopCommand = cmd;
    snoopValid   = 1'b1;
    while (!snoopReady && n < 300) begin @(posedge clock); #1; n++; end
    chk("accept_timeout", snoopReady, 1);
    @(posedge clock); #1;
    snoopValid = 1'b0;
    lat = 1;
    while (!responseValid && lat < 300) begin @(posedge clock); #1; lat++; end
    chk("response_timeout", responseValid, 1);
    rh = responseHit;
    rf = responseFlush;
    repeat (rdelay) begin @(posedge clock); #1; end
    responseReady = 1'b1;
    @(posedge clock); #1;
    responseReady = 1'b0;
  endtask

  initial begin
    int         lat, n;
    logic       rh, rf;
    logic [5:0] t, ix;

    #12;
    chk("reset_snoopReady", snoopReady, 1);
    chk("reset_flushValid", flushValid, 0);
    chk("reset_responseValid", responseValid, 0);
    chk("reset_writeState", writeState, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Miss on an empty cache: READ to 0x0A53.
    snoop(6'h02, 6'h25, 4'h3, 2'b01, 0, lat, rh, rf);
    chk("miss_latency", lat, 2);
    chk("miss_hit", rh, 0);
    chk("miss_flush", rf, 0);

    // SHARED line invalidated without flush.
    preload(6'd5, 6'd9, 1'b1, SHARED);
    snoop(6'd5, 6'd9, 4'h0, 2'b11, 1, lat, rh, rf);
    chk("inv_latency", lat, 3);
    chk("inv_hit", rh, 1);
    chk("inv_flush", rf, 0);
    chk("inv_state", state_a[5][9], INVALID);

    // MODIFIED line, READ, bus always ready.
    fmode = 0;
    preload(6'd7, 6'd33, 1'b1, MODIFIED);
    snoop(6'd7, 6'd33, 4'h9, 2'b01, 0, lat, rh, rf);
    chk("mod_read_latency", lat, 19);
    chk("mod_read_hit", rh, 1);
    chk("mod_read_flush", rf, 1);
    chk("mod_read_state", state_a[7][33], SHARED);

    // MODIFIED line, READ_EXCLUSIVE, bus ready toggling.
    fmode = 1;
    preload(6'd8, 6'd12, 1'b1, MODIFIED);
    snoop(6'd8, 6'd12, 4'hF, 2'b10, 2, lat, rh, rf);
    chk("mod_rdx_latency_34_or_35", (lat == 34 || lat == 35), 1);
    chk("mod_rdx_hit", rh, 1);
    chk("mod_rdx_flush", rf, 1);
    chk("mod_rdx_state", state_a[8][12], INVALID);

    // Back-to-back: second request held on the bus while the first response stalls.
    fmode = 2;
    preload(6'd9, 6'd1, 1'b1, SHARED);
    snoopAddress = {6'd9, 6'd1, 4'd0};
    snoopCommand = 2'b01;
    snoopValid   = 1'b1;
    n = 0;
    while (!snoopReady && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    snoopAddress = {6'd10, 6'd2, 4'd5};
    snoopCommand = 2'b11;
    n = 0;
    while (!responseValid && n < 50) begin @(posedge clock); #1; n++; end
    chk("b2b_first_response", responseValid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("b2b_stall_ready", snoopReady, 0);
      chk("b2b_stall_resp_held", responseValid, 1);
      @(posedge clock); #1;
    end
    responseReady = 1'b1;
    @(posedge clock); #1;
    responseReady = 1'b0;
    chk("b2b_second_ready", snoopReady, 1);
    @(posedge clock); #1;
    snoopValid = 1'b0;
    chk("b2b_second_accepted", snoopReady, 0);
    n = 0;
    while (!responseValid && n < 50) begin @(posedge clock); #1; n++; end
    chk("b2b_second_hit", responseHit, 0);
    responseReady = 1'b1;
    @(posedge clock); #1;
    responseReady = 1'b0;
    chk("b2b_first_state", state_a[9][1], SHARED);

    // Reset during flush beat 7.
    fmode = 0;
    preload(6'd11, 6'd40, 1'b1, MODIFIED);
    snoopAddress = {6'd11, 6'd40, 4'd2};
    snoopCommand = 2'b01;
    snoopValid   = 1'b1;
    n = 0;
    while (!snoopReady && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    snoopValid = 1'b0;
    n = 0;
    while (!(flushValid && offset == 4'd7) && n < 50) begin @(posedge clock); #1; n++; end
    chk("reached_beat7", offset, 7);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_snoopReady", snoopReady, 1);
    chk("arst_flushValid", flushValid, 0);
    chk("arst_flushData", flushData, 0);
    chk("arst_writeState", writeState, 0);
    chk("arst_responseValid", responseValid, 0);
`ifdef SNOOPY_CONTROLLER_STATISTICS_EN
    chk("arst_snoopHitCount", snoopHitCount, 0);
    chk("arst_invalidateCount", invalidateCount, 0);
`endif
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("arst_line_untouched", state_a[11][40], MODIFIED);

    // Random snoops over a small pool of lines so hits of every state recur.
    for (int k = 0; k < 150; k++) begin
      t  = 6'($urandom_range(0, 3));
      ix = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) preload(t, ix, 1'($urandom), 2'($urandom_range(0, 2)));
      fmode = $urandom_range(0, 2);
      snoop(t, ix, 4'($urandom), 2'($urandom), $urandom_range(0, 3), lat, rh, rf);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
